// File: rtl/dm_read_responder_if.sv
// Handshake bundle for dm_read_responder: command/status streams, AXI read
// channels and the output data stream. The master modport is the responder's view.
interface dm_read_responder_if #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 64
);
  logic                        cmd_tvalid;
  logic                        cmd_tready;
  logic [MM_ADDR_WIDTH+39:0]   cmd_tdata;
  logic                        sts_tvalid;
  logic                        sts_tready;
  logic [7:0]                  sts_tdata;
  logic                        sts_tkeep;
  logic                        sts_tlast;
  logic                        sts_err;
  logic [MM_ADDR_WIDTH-1:0]    m_axi_araddr;
  logic [7:0]                  m_axi_arlen;
  logic [2:0]                  m_axi_arsize;
  logic [1:0]                  m_axi_arburst;
  logic                        m_axi_arvalid;
  logic                        m_axi_arready;
  logic [DATA_WIDTH-1:0]       m_axi_rdata;
  logic [1:0]                  m_axi_rresp;
  logic                        m_axi_rlast;
  logic                        m_axi_rvalid;
  logic                        m_axi_rready;
  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic [DATA_WIDTH/8-1:0]     m_axis_tkeep;
  logic                        m_axis_tlast;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;

  modport master (
    input  cmd_tvalid, cmd_tdata, sts_tready, m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, m_axis_tready,
    output cmd_tready, sts_tvalid, sts_tdata, sts_tkeep, sts_tlast, sts_err,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_rready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output cmd_tvalid, cmd_tdata, sts_tready, m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, m_axis_tready,
    input  cmd_tready, sts_tvalid, sts_tdata, sts_tkeep, sts_tlast, sts_err,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_rready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/dm_read_responder.sv
// Single-command AXI read datamover: splits a command into AR bursts and streams R data out.
// Optional macro DM_RESP_4K_SPLIT_EN keeps incrementing bursts inside 4 KB pages.
module dm_read_responder #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_BURST     = 16
) (
  input  logic clk,
  input  logic rstn,
  dm_read_responder_if.master bus
);
  localparam int BPB     = DATA_WIDTH / 8;
  localparam int LOG_BPB = $clog2(BPB);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    AR_ISSUE = 3'd2,
    DATA     = 3'd3,
    STATUS   = 3'd4
  } state_t;

  state_t                   state_r, state_s;
  logic                     cmd_tready_r, arvalid_r, sts_tvalid_r, sts_err_r;
  logic [MM_ADDR_WIDTH-1:0] araddr_r, addr_r, addr_s;
  logic [7:0]               arlen_r, sts_tdata_r;
  logic [22:0]              btt_r;
  logic                     incr_r, eof_r;
  logic [3:0]               tag_r;
  logic [23:0]              rem_r, rem_s, total_s;
  logic [8:0]               blen_r, blen_s, beat_r, beat_s;
  logic                     slverr_r, decerr_r, interr_r, slverr_s, decerr_s, interr_s;
  logic                     cmd_fire_s, beat_fire_s, burst_end_s, final_s, in_data_s;
  logic [BPB-1:0]           keep_s;
  logic                     unused_s;

  assign unused_s    = ^{bus.cmd_tdata[31:24], bus.cmd_tdata[MM_ADDR_WIDTH+39:MM_ADDR_WIDTH+36]};
  assign cmd_fire_s  = cmd_tready_r & bus.cmd_tvalid;
  assign in_data_s   = (state_r == DATA);
  assign beat_fire_s = in_data_s & bus.m_axi_rvalid & bus.m_axis_tready;
  assign final_s     = (rem_r == 24'd1);
  assign total_s     = ({1'b0, btt_r} + 24'(BPB - 1)) >> LOG_BPB;

  // Burst length for the next AR, taken from the values the state registers are about to hold.
  always_comb begin
    if (rem_s > 24'(MAX_BURST)) blen_s = 9'(MAX_BURST);
    else                        blen_s = rem_s[8:0];
`ifdef DM_RESP_4K_SPLIT_EN
    begin : page_split
      logic [12:0] to4k_s;
      to4k_s = (13'h1000 - {1'b0, addr_s[11:0]}) >> LOG_BPB;
      if (incr_r && (to4k_s < {4'd0, blen_s})) blen_s = to4k_s[8:0];
      else                                    blen_s = blen_s;
    end
`endif
  end

  // Next-state and per-command bookkeeping.
  always_comb begin
    state_s     = state_r;
    rem_s       = rem_r;
    addr_s      = addr_r;
    beat_s      = beat_r;
    slverr_s    = slverr_r;
    decerr_s    = decerr_r;
    interr_s    = interr_r;
    burst_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          state_s  = DECODE;
          addr_s   = bus.cmd_tdata[32 +: MM_ADDR_WIDTH];
          slverr_s = 1'b0;
          decerr_s = 1'b0;
          interr_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      DECODE: begin
        if ((btt_r == 23'd0) || (addr_r[LOG_BPB-1:0] != {LOG_BPB{1'b0}})) begin
          interr_s = 1'b1;
          state_s  = STATUS;
        end else begin
          rem_s   = total_s;
          state_s = AR_ISSUE;
        end
      end
      AR_ISSUE: begin
        if (arvalid_r && bus.m_axi_arready) begin
          beat_s  = 9'd0;
          state_s = DATA;
        end else begin
          state_s = AR_ISSUE;
        end
      end
      DATA: begin
        if (beat_fire_s) begin
          rem_s  = rem_r - 24'd1;
          beat_s = beat_r + 9'd1;
          if (bus.m_axi_rresp == 2'b10)      slverr_s = 1'b1;
          else if (bus.m_axi_rresp == 2'b11) decerr_s = 1'b1;
          else                               slverr_s = slverr_r;
          // The beat count decides where a burst ends; rlast is only cross-checked.
          burst_end_s = (beat_r == (blen_r - 9'd1));
          if (bus.m_axi_rlast != burst_end_s) interr_s = 1'b1;
          else                                interr_s = interr_r;
          if (burst_end_s) begin
            if (incr_r) addr_s = addr_r + (MM_ADDR_WIDTH'(blen_r) << LOG_BPB);
            else        addr_s = addr_r;
            state_s = (rem_s == 24'd0) ? STATUS : AR_ISSUE;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      STATUS: begin
        if (sts_tvalid_r && bus.sts_tready) state_s = IDLE;
        else                                state_s = STATUS;
      end
      default: state_s = IDLE;
    endcase
  end

  // Final-beat byte enables: low (BTT mod bytes-per-beat) lanes, all lanes when it divides evenly.
  always_comb begin
    keep_s = {BPB{1'b1}};
    if (final_s && (btt_r[LOG_BPB-1:0] != {LOG_BPB{1'b0}})) begin
      for (int i = 0; i < BPB; i++) keep_s[i] = (i < int'(btt_r[LOG_BPB-1:0]));
    end else begin
      keep_s = {BPB{1'b1}};
    end
  end

  // State, command capture, AR and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      cmd_tready_r <= 1'b0;
      btt_r        <= 23'd0;
      incr_r       <= 1'b0;
      eof_r        <= 1'b0;
      tag_r        <= 4'd0;
      addr_r       <= {MM_ADDR_WIDTH{1'b0}};
      rem_r        <= 24'd0;
      beat_r       <= 9'd0;
      blen_r       <= 9'd0;
      slverr_r     <= 1'b0;
      decerr_r     <= 1'b0;
      interr_r     <= 1'b0;
      arvalid_r    <= 1'b0;
      araddr_r     <= {MM_ADDR_WIDTH{1'b0}};
      arlen_r      <= 8'd0;
      sts_tvalid_r <= 1'b0;
      sts_tdata_r  <= 8'd0;
      sts_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cmd_tready_r <= (state_s == IDLE);
      addr_r       <= addr_s;
      rem_r        <= rem_s;
      beat_r       <= beat_s;
      slverr_r     <= slverr_s;
      decerr_r     <= decerr_s;
      interr_r     <= interr_s;
      sts_err_r    <= sts_tvalid_r & bus.sts_tready & (|sts_tdata_r[6:4]);
      if (cmd_fire_s) begin
        btt_r  <= bus.cmd_tdata[22:0];
        incr_r <= bus.cmd_tdata[23];
        eof_r  <= bus.cmd_tdata[30];
        tag_r  <= bus.cmd_tdata[MM_ADDR_WIDTH+32 +: 4];
      end
      if ((state_r != AR_ISSUE) && (state_s == AR_ISSUE)) begin
        arvalid_r <= 1'b1;
        araddr_r  <= addr_s;
        arlen_r   <= 8'(blen_s - 9'd1);
        blen_r    <= blen_s;
      end else if (arvalid_r && bus.m_axi_arready) begin
        arvalid_r <= 1'b0;
      end
      if ((state_r != STATUS) && (state_s == STATUS)) begin
        sts_tvalid_r <= 1'b1;
        sts_tdata_r  <= {~(slverr_s | decerr_s | interr_s), slverr_s, decerr_s, interr_s, tag_r};
      end else if (sts_tvalid_r && bus.sts_tready) begin
        sts_tvalid_r <= 1'b0;
      end
    end
  end

  assign bus.cmd_tready    = cmd_tready_r;
  assign bus.sts_tvalid    = sts_tvalid_r;
  assign bus.sts_tdata     = sts_tdata_r;
  assign bus.sts_tkeep     = 1'b1;
  assign bus.sts_tlast     = 1'b1;
  assign bus.sts_err       = sts_err_r;
  assign bus.m_axi_araddr  = araddr_r;
  assign bus.m_axi_arlen   = arlen_r;
  assign bus.m_axi_arsize  = 3'(LOG_BPB);
  assign bus.m_axi_arburst = {1'b0, incr_r};
  assign bus.m_axi_arvalid = arvalid_r;
  assign bus.m_axi_rready  = in_data_s & bus.m_axis_tready;
  assign bus.m_axis_tvalid = in_data_s & bus.m_axi_rvalid;
  assign bus.m_axis_tdata  = bus.m_axi_rdata;
  assign bus.m_axis_tkeep  = keep_s;
  assign bus.m_axis_tlast  = in_data_s & final_s & eof_r;
endmodule

// File: tb/tb_dm_read_responder.sv
// Directed bench for dm_read_responder: a small AXI read slave plus stream/status sink,
// with one task per scenario checking hand-computed expectations.
module tb_dm_read_responder;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dm_read_responder_if #(.MM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dm_read_responder #(.MM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(16)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] ar_addr [8];
  logic [7:0]  ar_len  [8];
  logic [1:0]  ar_burst0;
  logic [2:0]  ar_size0;
  int          n_ar, n_beats, n_tlast, last_tlast_beat, data_err, n_partial, sts_err_cnt, ar_lat;
  logic [7:0]  last_keep, sts_val;
  logic        sts_seen, aborted;

  function automatic logic [63:0] pat(input int idx);
    return 64'hD00D_0000_0000_0000 + 64'(idx);
  endfunction

  task automatic idle_inputs;
    bus.cmd_tvalid    = 1'b0;
    bus.cmd_tdata     = '0;
    bus.sts_tready    = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axis_tready = 1'b1;
  endtask

  // Issue one command and act as AXI slave / stream sink until status is taken (or abort point).
  task automatic run_cmd(input logic [22:0] btt, input logic incr, input logic eof,
                         input logic [31:0] saddr, input logic [3:0] tag, input int err_beat,
                         input logic [1:0] err_resp, input logic tog, input logic early_last,
                         input int abort_after);
    int   pending = 0;
    int   bb = 0;
    int   beat_idx = 0;
    int   acc = -1;
    int   post = 0;
    logic sent = 1'b0;
    n_ar = 0; n_beats = 0; n_tlast = 0; last_tlast_beat = -1; data_err = 0; n_partial = 0;
    sts_err_cnt = 0; ar_lat = -1; last_keep = 8'h00; sts_val = 8'h00; sts_seen = 1'b0;
    aborted = 1'b0; ar_burst0 = 2'b11; ar_size0 = 3'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (bus.sts_err === 1'b1) sts_err_cnt++;
      if (sts_seen) begin
        post++;
        if (post > 4) break;
      end
      bus.cmd_tvalid    = !sent;
      bus.cmd_tdata     = {4'h0, tag, saddr, 1'b0, eof, 6'h2A, incr, btt};
      bus.m_axi_arready = cyc[0];
      bus.m_axi_rvalid  = (pending > 0);
      bus.m_axi_rlast   = early_last ? ((pending > 0) && (bb == 0)) : (pending == 1);
      bus.m_axi_rdata   = pat(beat_idx);
      bus.m_axi_rresp   = (beat_idx == err_beat) ? err_resp : 2'b00;
      bus.m_axis_tready = tog ? cyc[0] : 1'b1;
      bus.sts_tready    = cyc[1];
      #1;
      if (bus.cmd_tvalid && bus.cmd_tready) begin
        sent = 1'b1;
        acc  = cyc;
      end
      if ((acc >= 0) && (ar_lat < 0) && bus.m_axi_arvalid) ar_lat = cyc - acc;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        if (n_ar == 0) begin
          ar_burst0 = bus.m_axi_arburst;
          ar_size0  = bus.m_axi_arsize;
        end
        if (n_ar < 8) begin
          ar_addr[n_ar] = bus.m_axi_araddr;
          ar_len[n_ar]  = bus.m_axi_arlen;
        end
        n_ar++;
        pending = int'(bus.m_axi_arlen) + 1;
        bb = 0;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if ((bus.m_axis_tdata !== pat(beat_idx)) || (bus.m_axi_rready !== 1'b1)) data_err++;
        if (bus.m_axis_tlast) begin
          n_tlast++;
          last_tlast_beat = beat_idx;
        end
        if (bus.m_axis_tkeep !== 8'hFF) n_partial++;
        last_keep = bus.m_axis_tkeep;
        beat_idx++;
        n_beats++;
        pending--;
        bb++;
      end
      if (bus.sts_tvalid && bus.sts_tready) begin
        sts_seen = 1'b1;
        sts_val  = bus.sts_tdata;
      end
      if ((abort_after >= 0) && (n_beats >= abort_after)) begin
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) idle_inputs();
  endtask

  task automatic test_reset;
    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.cmd_tready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_tready got %b want 0", bus.cmd_tready); end
    n_cmp++; if (bus.sts_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_sts_tvalid got %b want 0", bus.sts_tvalid); end
    n_cmp++; if (bus.sts_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_sts_tdata got %h want 00", bus.sts_tdata); end
    n_cmp++; if (bus.sts_err !== 1'b0) begin n_fail++; $display("FAIL reset_sts_err got %b want 0", bus.sts_err); end
    n_cmp++; if (bus.m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b want 0", bus.m_axi_arvalid); end
    n_cmp++; if ({bus.m_axi_araddr, bus.m_axi_arlen} !== 40'h0) begin n_fail++; $display("FAIL reset_araddr_arlen got %h/%h want 0/0", bus.m_axi_araddr, bus.m_axi_arlen); end
    n_cmp++; if ({bus.m_axi_rready, bus.m_axis_tvalid, bus.m_axis_tlast} !== 3'b000) begin n_fail++; $display("FAIL reset_stream got %b want 000", {bus.m_axi_rready, bus.m_axis_tvalid, bus.m_axis_tlast}); end
    rstn = 1'b1;
    #1;
    n_cmp++; if (bus.cmd_tready !== 1'b0) begin n_fail++; $display("FAIL release_cmd_tready got %b want 0", bus.cmd_tready); end
    @(negedge clk);
    n_cmp++; if (bus.cmd_tready !== 1'b1) begin n_fail++; $display("FAIL first_cycle_cmd_tready got %b want 1", bus.cmd_tready); end
  endtask

  task automatic test_two_bursts;
    run_cmd(23'd256, 1'b1, 1'b1, 32'h1000, 4'h3, -1, 2'b00, 1'b0, 1'b0, -1);
    n_cmp++; if (n_ar !== 2) begin n_fail++; $display("FAIL two_bursts n_ar got %0d want 2", n_ar); end
    n_cmp++; if ({ar_addr[0], ar_len[0]} !== {32'h1000, 8'd15}) begin n_fail++; $display("FAIL two_bursts ar0 got %h/%0d want 1000/15", ar_addr[0], ar_len[0]); end
    n_cmp++; if ({ar_addr[1], ar_len[1]} !== {32'h1080, 8'd15}) begin n_fail++; $display("FAIL two_bursts ar1 got %h/%0d want 1080/15", ar_addr[1], ar_len[1]); end
    n_cmp++; if (n_beats !== 32) begin n_fail++; $display("FAIL two_bursts beats got %0d want 32", n_beats); end
    n_cmp++; if ((n_tlast !== 1) || (last_tlast_beat !== 31)) begin n_fail++; $display("FAIL two_bursts tlast got %0d@%0d want 1@31", n_tlast, last_tlast_beat); end
    n_cmp++; if ((data_err !== 0) || (n_partial !== 0)) begin n_fail++; $display("FAIL two_bursts data got err=%0d partial=%0d want 0/0", data_err, n_partial); end
    n_cmp++; if (sts_val !== 8'h83) begin n_fail++; $display("FAIL two_bursts sts got %h want 83", sts_val); end
    n_cmp++; if (ar_lat !== 2) begin n_fail++; $display("FAIL accept_to_arvalid got %0d want 2", ar_lat); end
    n_cmp++; if ((ar_size0 !== 3'd3) || (ar_burst0 !== 2'b01)) begin n_fail++; $display("FAIL two_bursts size_burst got %0d/%b want 3/01", ar_size0, ar_burst0); end
    n_cmp++; if (sts_err_cnt !== 0) begin n_fail++; $display("FAIL two_bursts sts_err got %0d want 0", sts_err_cnt); end
  endtask

  task automatic test_partial;
    run_cmd(23'd20, 1'b1, 1'b1, 32'h0, 4'h0, -1, 2'b00, 1'b0, 1'b0, -1);
    n_cmp++; if ((n_ar !== 1) || (ar_len[0] !== 8'd2)) begin n_fail++; $display("FAIL partial ar got %0d/%0d want 1/2", n_ar, ar_len[0]); end
    n_cmp++; if ((last_keep !== 8'h0F) || (n_partial !== 1)) begin n_fail++; $display("FAIL partial tkeep got %h/%0d want 0f/1", last_keep, n_partial); end
    n_cmp++; if ((n_beats !== 3) || (last_tlast_beat !== 2)) begin n_fail++; $display("FAIL partial beats got %0d last@%0d want 3@2", n_beats, last_tlast_beat); end
    n_cmp++; if (sts_val !== 8'h80) begin n_fail++; $display("FAIL partial sts got %h want 80", sts_val); end
  endtask

  task automatic test_fixed_no_eof;
    run_cmd(23'd200, 1'b0, 1'b0, 32'h2000, 4'hA, -1, 2'b00, 1'b0, 1'b0, -1);
    n_cmp++; if (n_ar !== 2) begin n_fail++; $display("FAIL fixed n_ar got %0d want 2", n_ar); end
    n_cmp++; if ({ar_addr[0], ar_len[0], ar_addr[1], ar_len[1]} !== {32'h2000, 8'd15, 32'h2000, 8'd8}) begin n_fail++; $display("FAIL fixed ar got %h/%0d %h/%0d want 2000/15 2000/8", ar_addr[0], ar_len[0], ar_addr[1], ar_len[1]); end
    n_cmp++; if (ar_burst0 !== 2'b00) begin n_fail++; $display("FAIL fixed arburst got %b want 00", ar_burst0); end
    n_cmp++; if ((n_beats !== 25) || (n_tlast !== 0) || (last_keep !== 8'hFF)) begin n_fail++; $display("FAIL fixed stream got beats=%0d tlast=%0d keep=%h want 25/0/ff", n_beats, n_tlast, last_keep); end
    n_cmp++; if (sts_val !== 8'h8A) begin n_fail++; $display("FAIL fixed sts got %h want 8a", sts_val); end
  endtask

  task automatic test_4k;
    run_cmd(23'd128, 1'b1, 1'b1, 32'h0FC0, 4'h1, -1, 2'b00, 1'b0, 1'b0, -1);
`ifdef DM_RESP_4K_SPLIT_EN
    n_cmp++; if (n_ar !== 2) begin n_fail++; $display("FAIL split4k n_ar got %0d want 2", n_ar); end
    n_cmp++; if ({ar_addr[0], ar_len[0], ar_addr[1], ar_len[1]} !== {32'h0FC0, 8'd7, 32'h1000, 8'd7}) begin n_fail++; $display("FAIL split4k ar got %h/%0d %h/%0d want 0fc0/7 1000/7", ar_addr[0], ar_len[0], ar_addr[1], ar_len[1]); end
`else
    n_cmp++; if ((n_ar !== 1) || ({ar_addr[0], ar_len[0]} !== {32'h0FC0, 8'd15})) begin n_fail++; $display("FAIL nosplit4k ar got %0d %h/%0d want 1 0fc0/15", n_ar, ar_addr[0], ar_len[0]); end
`endif
    n_cmp++; if ((n_beats !== 16) || (sts_val !== 8'h81)) begin n_fail++; $display("FAIL 4k beats_sts got %0d/%h want 16/81", n_beats, sts_val); end
  endtask

  task automatic test_decode_errors;
    run_cmd(23'd64, 1'b1, 1'b1, 32'h1004, 4'h5, -1, 2'b00, 1'b0, 1'b0, -1);
    n_cmp++; if ((n_ar !== 0) || (ar_lat !== -1)) begin n_fail++; $display("FAIL unaligned ar got n_ar=%0d lat=%0d want 0/-1", n_ar, ar_lat); end
    n_cmp++; if (sts_val !== 8'h15) begin n_fail++; $display("FAIL unaligned sts got %h want 15", sts_val); end
    n_cmp++; if (sts_err_cnt !== 1) begin n_fail++; $display("FAIL unaligned sts_err got %0d want 1", sts_err_cnt); end
    run_cmd(23'd0, 1'b1, 1'b1, 32'h0100, 4'h4, -1, 2'b00, 1'b0, 1'b0, -1);
    n_cmp++; if ((n_ar !== 0) || (sts_val !== 8'h14)) begin n_fail++; $display("FAIL btt0 got n_ar=%0d sts=%h want 0/14", n_ar, sts_val); end
  endtask

  task automatic test_slverr_backpressure;
    run_cmd(23'd256, 1'b1, 1'b1, 32'h3000, 4'h9, 5, 2'b10, 1'b1, 1'b0, -1);
    n_cmp++; if ((n_beats !== 32) || (data_err !== 0)) begin n_fail++; $display("FAIL slverr stream got beats=%0d err=%0d want 32/0", n_beats, data_err); end
    n_cmp++; if (last_tlast_beat !== 31) begin n_fail++; $display("FAIL slverr tlast got %0d want 31", last_tlast_beat); end
    n_cmp++; if (sts_val !== 8'h49) begin n_fail++; $display("FAIL slverr sts got %h want 49", sts_val); end
    n_cmp++; if (sts_err_cnt !== 1) begin n_fail++; $display("FAIL slverr sts_err got %0d want 1", sts_err_cnt); end
  endtask

  task automatic test_rlast_decerr;
    run_cmd(23'd64, 1'b1, 1'b1, 32'h4000, 4'h2, 3, 2'b11, 1'b0, 1'b1, -1);
    n_cmp++; if ((n_ar !== 1) || (n_beats !== 8) || (data_err !== 0)) begin n_fail++; $display("FAIL early_rlast got ar=%0d beats=%0d err=%0d want 1/8/0", n_ar, n_beats, data_err); end
    n_cmp++; if (sts_val !== 8'h32) begin n_fail++; $display("FAIL early_rlast sts got %h want 32", sts_val); end
  endtask

  task automatic test_reset_mid;
    run_cmd(23'd256, 1'b1, 1'b1, 32'h5000, 4'h6, -1, 2'b00, 1'b0, 1'b0, 3);
    n_cmp++; if ((aborted !== 1'b1) || (bus.m_axis_tvalid !== 1'b1)) begin n_fail++; $display("FAIL midreset reach_data got %b/%b want 1/1", aborted, bus.m_axis_tvalid); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if ({bus.m_axis_tvalid, bus.m_axi_rready, bus.m_axi_arvalid, bus.sts_tvalid, bus.cmd_tready} !== 5'b0) begin n_fail++; $display("FAIL midreset valids got %b want 00000", {bus.m_axis_tvalid, bus.m_axi_rready, bus.m_axi_arvalid, bus.sts_tvalid, bus.cmd_tready}); end
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    run_cmd(23'd64, 1'b1, 1'b1, 32'h6000, 4'h7, -1, 2'b00, 1'b0, 1'b0, -1);
    n_cmp++; if ((n_ar !== 1) || (ar_addr[0] !== 32'h6000) || (n_beats !== 8)) begin n_fail++; $display("FAIL after_reset got ar=%0d %h beats=%0d want 1 6000 8", n_ar, ar_addr[0], n_beats); end
    n_cmp++; if (sts_val !== 8'h87) begin n_fail++; $display("FAIL after_reset sts got %h want 87", sts_val); end
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_partial();
    test_fixed_no_eof();
    test_4k();
    test_decode_errors();
    test_slverr_backpressure();
    test_rlast_decerr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
